// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a framed program image byte-by-byte and writes it
// into instruction memory, holding the CPU in reset until a good image is loaded.
module imem_uart_loader #(
    parameter int          ADDR_WIDTH = 7,
    parameter int          TIMEOUT    = 50000000,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int CNTW = ADDR_WIDTH + 1;
    localparam int CW   = (CNTW > 8) ? CNTW : 8;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, GET_CNT, GET_DATA, GET_CSUM} state_t;

    state_t                state_reg;
    logic [1:0]            byte_idx_reg;
    logic [23:0]           word_reg;
    logic [CNTW-1:0]       cnt_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [7:0]            csum_reg;
    logic [TW-1:0]         tmo_reg;

    logic [CW-1:0] rx_count;
    logic          timeout_hit;
    logic [7:0]    csum_next;

    assign rx_count    = CW'(rx_data);
    assign csum_next   = csum_reg ^ rx_data;
    assign timeout_hit = (state_reg != IDLE) && !rx_valid && (tmo_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            cnt_reg      <= '0;
            waddr_reg    <= '0;
            csum_reg     <= '0;
            tmo_reg      <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            // Inter-byte watchdog only runs while a frame is open.
            if (rx_valid || state_reg == IDLE)
                tmo_reg <= '0;
            else
                tmo_reg <= tmo_reg + 1'b1;

            if (timeout_hit) begin
                load_err  <= 1'b1;
                load_busy <= 1'b0;
                state_reg <= IDLE;
            end else if (rx_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (rx_data == HEADER) begin
                            cpu_hold     <= 1'b1;
                            load_busy    <= 1'b1;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            csum_reg     <= '0;
                            state_reg    <= GET_CNT;
                        end
                    end
                    GET_CNT: begin
                        if (rx_count == '0 || rx_count > MAX_WORDS) begin
                            load_err  <= 1'b1;
                            load_busy <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg      <= CNTW'(rx_data);
                            waddr_reg    <= '0;
                            byte_idx_reg <= '0;
                            state_reg    <= GET_DATA;
                        end
                    end
                    GET_DATA: begin
                        csum_reg     <= csum_next;
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        case (byte_idx_reg)
                            2'd0: word_reg[7:0]   <= rx_data;
                            2'd1: word_reg[15:8]  <= rx_data;
                            2'd2: word_reg[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word; write it next cycle.
                                imem_we      <= 1'b1;
                                imem_waddr   <= waddr_reg;
                                imem_wdata   <= {rx_data, word_reg};
                                waddr_reg    <= waddr_reg + 1'b1;
                                words_loaded <= words_loaded + 1'b1;
                                if (words_loaded + 1'b1 == cnt_reg)
                                    state_reg <= GET_CSUM;
                            end
                        endcase
                    end
                    GET_CSUM: begin
                        load_busy <= 1'b0;
                        state_reg <= IDLE;
                        if (rx_data == csum_reg) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
